// File: rtl/req_wb_bridge_pkg.sv
// req_wb_bridge_pkg: FSM encoding and bus constants shared with the CPU interface stage
package req_wb_bridge_pkg;
   typedef enum logic [1:0] {IDLE, RD_REQ, WR_WAIT, WR_REQ} state_t;
   localparam logic [2:0] LEN_SINGLE = 3'd1;
   localparam logic [2:0] LEN_LINE = 3'd4;
   localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is accepted only alongside a pop
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic do_push, do_pop;
   assign empty = wp == rp;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign pop_data = mem[rp[AW-1:0]];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
      end
   always_ff @(posedge clk)
      if (do_push) mem[wp[AW-1:0]] <= push_data;
endmodule

// File: rtl/req_wb_bridge.sv
// req_wb_bridge: runs CPU bus requests as 1 or 4 Wishbone classic single-beat cycles
// Defining REQ_WB_BRIDGE_TIMEOUT_EN forces beat completion after TIMEOUT unacked strobe cycles.
module req_wb_bridge
   import req_wb_bridge_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_len,
   input  logic [3:0]  req_mask,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic        write_valid,
   input  logic [31:0] write_data,
   output logic        read_valid,
   output logic [31:0] read_data,
   input  logic        read_ack,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   output logic        wr_ovf_o
);
   state_t state;
   logic run, line, done, last, to_hit, bus_err;
   logic [31:2] addr;
   logic [3:0] mask;
   logic [1:0] beat;
   logic [31:0] cur_adr, wr_head;
   logic [3:0] cur_sel;
   logic wr_full, wr_empty, wr_pop, rd_full, rd_empty, rd_push;
   // run keeps req_ready low while reset is held and for the first clock after release
   assign req_ready = run && state == IDLE && rd_empty;
   assign read_valid = !rd_empty;
   assign done = wb_stb_o && (wb_ack_i || wb_err_i || to_hit);
   assign bus_err = wb_err_i || (to_hit && !wb_ack_i);
   assign last = !line || beat == 2'd3;
   assign rd_push = done && !wb_we_o;
   assign wr_pop = done && wb_we_o;
   assign cur_adr = {addr[31:4], addr[3:2] + beat, 2'b00};
   assign cur_sel = line ? 4'hF : mask;
`ifdef REQ_WB_BRIDGE_TIMEOUT_EN
   logic [15:0] to_cnt;
   assign to_hit = wb_stb_o && to_cnt == 16'(TIMEOUT - 1);
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) to_cnt <= '0;
      else to_cnt <= (wb_stb_o && !done) ? to_cnt + 16'd1 : '0;
`else
   assign to_hit = 1'b0;
`endif
   sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
      .clk(clk_i), .rst(rst_i), .push(write_valid), .push_data(write_data),
      .pop(wr_pop), .pop_data(wr_head), .full(wr_full), .empty(wr_empty)
   );
   sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
      .clk(clk_i), .rst(rst_i), .push(rd_push), .push_data(bus_err ? ERR_DATA : wb_dat_i),
      .pop(read_ack), .pop_data(read_data), .full(rd_full), .empty(rd_empty)
   );
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state <= IDLE;
         run <= 1'b0;
         line <= 1'b0;
         addr <= '0;
         mask <= '0;
         beat <= '0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o <= 1'b0;
         wb_adr_o <= '0;
         wb_sel_o <= '0;
         wb_dat_o <= '0;
         wr_ovf_o <= 1'b0;
      end else begin
         run <= 1'b1;
         if (write_valid && wr_full && !wr_pop) wr_ovf_o <= 1'b1;
         if (done) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            beat <= beat + 2'd1;
         end
         case (state)
            IDLE:
               if (req_valid && req_ready) begin
                  addr <= req_addr[31:2];
                  line <= req_len == LEN_LINE;
                  mask <= req_mask;
                  beat <= '0;
                  state <= req_we ? WR_WAIT : RD_REQ;
               end
            RD_REQ:
               if (done) state <= last ? IDLE : RD_REQ;
               else if (!wb_cyc_o && !rd_full) begin
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  wb_we_o <= 1'b0;
                  wb_adr_o <= cur_adr;
                  wb_sel_o <= cur_sel;
               end
            WR_WAIT:
               if (!wr_empty) begin
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  wb_we_o <= 1'b1;
                  wb_adr_o <= cur_adr;
                  wb_sel_o <= cur_sel;
                  wb_dat_o <= wr_head;
                  state <= WR_REQ;
               end
            WR_REQ:
               if (done) state <= last ? IDLE : WR_WAIT;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_req_wb_bridge.sv
// tb_req_wb_bridge: randomized request/Wishbone scoreboard bench for req_wb_bridge
module tb_req_wb_bridge;
   logic clk_i = 0, rst_i = 1;
   logic req_valid = 0, req_we = 0, write_valid = 0, read_ack = 0;
   logic [2:0] req_len = 0;
   logic [3:0] req_mask = 0;
   logic [31:0] req_addr = 0, write_data = 0;
   logic req_ready, read_valid, wb_cyc_o, wb_stb_o, wb_we_o, wr_ovf_o;
   logic [31:0] read_data, wb_adr_o, wb_dat_o;
   logic [3:0] wb_sel_o;
   logic [31:0] wb_dat_i = 0;
   logic wb_ack_i = 0, wb_err_i = 0;
   int checks = 0, errors = 0;
   typedef struct packed {logic [31:0] adr; logic [3:0] sel; logic we; logic [31:0] dat;} beat_t;
   beat_t log_q[$];
   logic [31:0] rd_exp_q[$], data_q[$], wr_q[$];
   int slave_delay = 1, err_at = -1, beat_no = 0;
   bit slave_hold = 0;

   req_wb_bridge #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid(req_valid), .req_ready(req_ready),
      .req_len(req_len), .req_mask(req_mask), .req_addr(req_addr), .req_we(req_we),
      .write_valid(write_valid), .write_data(write_data), .read_valid(read_valid),
      .read_data(read_data), .read_ack(read_ack), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wr_ovf_o(wr_ovf_o)
   );

   always #5 clk_i = ~clk_i;

   // Wishbone slave: acks after slave_delay strobe cycles, logs every completed beat
   initial begin
      int cnt = 0;
      forever begin
         @(negedge clk_i);
         if (wb_ack_i || wb_err_i) begin
            wb_ack_i = 0;
            wb_err_i = 0;
            cnt = 0;
         end else if (wb_cyc_o && wb_stb_o && !slave_hold && !rst_i) begin
            cnt++;
            if (cnt >= slave_delay) begin
               beat_t b;
               b.adr = wb_adr_o;
               b.sel = wb_sel_o;
               b.we = wb_we_o;
               b.dat = wb_dat_o;
               log_q.push_back(b);
               if (beat_no == err_at) begin
                  wb_err_i = 1;
                  if (!wb_we_o) rd_exp_q.push_back(32'hFFFF_FFFF);
               end else begin
                  wb_ack_i = 1;
                  if (data_q.size() > 0) wb_dat_i = data_q.pop_front();
                  else wb_dat_i = $urandom;
                  if (!wb_we_o) rd_exp_q.push_back(wb_dat_i);
               end
               beat_no++;
            end
         end else cnt = 0;
      end
   end

   function automatic logic [31:0] exp_adr(input logic [31:0] a, input int i);
      return (a & 32'hFFFF_FFF0) | ((a + 32'(4 * i)) & 32'h0000_000C);
   endfunction

   task automatic xact(input logic [31:0] a, input logic [2:0] len, input logic [3:0] mask,
                       input bit we, input int pd, input string nm);
      int n;
      bit line;
      logic [31:0] w[4];
      int k;
      line = len == 3'd4;
      n = line ? 4 : 1;
      for (int i = 0; i < 4; i++) w[i] = (i < n && wr_q.size() > 0) ? wr_q.pop_front() : $urandom;
      log_q.delete();
      rd_exp_q.delete();
      beat_no = 0;
      @(negedge clk_i);
      k = 0;
      while (!req_ready && k < 200) begin
         @(negedge clk_i);
         k++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s req_ready got %b exp 1", nm, req_ready);
      end
      req_valid = 1;
      req_addr = a;
      req_len = len;
      req_mask = mask;
      req_we = we;
      @(negedge clk_i);
      req_valid = 0;
      fork
         begin
            if (we) begin
               repeat (pd) @(negedge clk_i);
               for (int i = 0; i < n; i++) begin
                  write_valid = 1;
                  write_data = w[i];
                  @(negedge clk_i);
               end
               write_valid = 0;
            end
         end
         begin
            int t = 0;
            while (log_q.size() < n && t < 3000) begin
               @(negedge clk_i);
               t++;
            end
         end
      join
      repeat (2) @(negedge clk_i);
      checks++;
      if (log_q.size() != n) begin
         errors++;
         $display("FAIL %s beats got %0d exp %0d", nm, log_q.size(), n);
      end
      for (int i = 0; i < n && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i].adr !== exp_adr(a, i) || log_q[i].sel !== (line ? 4'hF : mask) ||
             log_q[i].we !== we || (we && log_q[i].dat !== w[i])) begin
            errors++;
            $display("FAIL %s beat%0d got adr %h sel %h we %b dat %h exp adr %h sel %h we %b dat %h",
                     nm, i, log_q[i].adr, log_q[i].sel, log_q[i].we, log_q[i].dat,
                     exp_adr(a, i), line ? 4'hF : mask, we, we ? w[i] : log_q[i].dat);
         end
      end
      if (!we) begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (req_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s req_ready_busy%0d got %b exp 0", nm, i, req_ready);
            end
            checks++;
            if (read_valid !== 1'b1 || read_data !== rd_exp_q[i]) begin
               errors++;
               $display("FAIL %s rdata%0d got v%b %h exp v1 %h", nm, i, read_valid, read_data, rd_exp_q[i]);
            end
            read_ack = 1;
            @(negedge clk_i);
         end
         read_ack = 0;
      end
      checks++;
      if (read_valid !== 1'b0 || req_ready !== 1'b1 || wr_ovf_o !== 1'b0) begin
         errors++;
         $display("FAIL %s idle got rv%b rdy%b ovf%b exp rv0 rdy1 ovf0", nm, read_valid, req_ready, wr_ovf_o);
      end
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, req_ready, read_valid, wr_ovf_o} !== 6'b0 ||
          {wb_adr_o, wb_sel_o, wb_dat_o} !== 68'b0) begin
         errors++;
         $display("FAIL reset_state got cyc%b stb%b we%b rdy%b rv%b ovf%b adr %h exp all 0",
                  wb_cyc_o, wb_stb_o, wb_we_o, req_ready, read_valid, wr_ovf_o, wb_adr_o);
      end
      repeat (3) @(negedge clk_i);
      rst_i = 0;
      repeat (2) @(negedge clk_i);
      checks++;
      if (req_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got rdy%b cyc%b exp rdy1 cyc0", req_ready, wb_cyc_o);
      end
   endtask

   task automatic test_directed;
      slave_delay = 2;
      data_q.push_back(32'hDEAD_BEEF);
      xact(32'h0000_1004, 3'd1, 4'hF, 0, 0, "single_read");
      slave_delay = 1;
      xact(32'h0000_2008, 3'd4, 4'hF, 0, 0, "line_read");
      err_at = 2;
      xact(32'h0000_2008, 3'd4, 4'hF, 0, 0, "line_read_err");
      err_at = -1;
      wr_q.push_back(32'h00AA_0000);
      xact(32'h0000_3001, 3'd1, 4'b0100, 1, 3, "byte_write");
      slave_delay = 8;
      xact(32'h0000_3008, 3'd4, 4'hF, 1, 0, "line_write");
      slave_delay = 1;
   endtask

   task automatic test_overflow;
      @(negedge clk_i);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (wr_ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early%0d got %b exp 0", i, wr_ovf_o);
         end
         write_valid = 1;
         write_data = 32'hBAD0_0000 + i;
         @(negedge clk_i);
      end
      write_valid = 0;
      checks++;
      if (wr_ovf_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set got %b exp 1", wr_ovf_o);
      end
   endtask

   task automatic test_reset_mid_write;
      int t = 0;
      slave_hold = 1;
      @(negedge clk_i);
      req_valid = 1;
      req_addr = 32'h0000_4000;
      req_len = 3'd4;
      req_mask = 4'hF;
      req_we = 1;
      @(negedge clk_i);
      req_valid = 0;
      while (!wb_stb_o && t < 50) begin
         @(negedge clk_i);
         t++;
      end
      checks++;
      if (wb_stb_o !== 1'b1) begin
         errors++;
         $display("FAIL stale_write_stb got %b exp 1", wb_stb_o);
      end
      #2 rst_i = 1;
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, wr_ovf_o, req_ready, read_valid} !== 5'b0) begin
         errors++;
         $display("FAIL async_reset got cyc%b stb%b ovf%b rdy%b rv%b exp all 0",
                  wb_cyc_o, wb_stb_o, wr_ovf_o, req_ready, read_valid);
      end
      @(negedge clk_i);
      rst_i = 0;
      slave_hold = 0;
      @(negedge clk_i);
      xact(32'h0000_4010, 3'd4, 4'hF, 1, 6, "post_reset_write");
   endtask

   task automatic test_random;
      for (int r = 0; r < 30; r++) begin
         logic [2:0] len;
         int n;
         bit we;
         len = ($urandom % 2) ? 3'd4 : 3'($urandom_range(0, 7));
         n = (len == 3'd4) ? 4 : 1;
         we = $urandom % 2;
         slave_delay = $urandom_range(1, 4);
         err_at = ($urandom % 3 == 0) ? $urandom_range(0, n - 1) : -1;
         xact($urandom, len, 4'($urandom), we, $urandom_range(0, 5), "random");
      end
      err_at = -1;
      slave_delay = 1;
   endtask

`ifdef REQ_WB_BRIDGE_TIMEOUT_EN
   task automatic test_timeout;
      int t = 0;
      slave_hold = 1;
      @(negedge clk_i);
      req_valid = 1;
      req_addr = 32'h0000_5000;
      req_len = 3'd1;
      req_mask = 4'hF;
      req_we = 0;
      @(negedge clk_i);
      req_valid = 0;
      while (!read_valid && t < 600) begin
         @(negedge clk_i);
         t++;
      end
      checks++;
      if (read_valid !== 1'b1 || read_data !== 32'hFFFF_FFFF || t < 250) begin
         errors++;
         $display("FAIL timeout got rv%b %h after %0d exp rv1 ffffffff after >=250", read_valid, read_data, t);
      end
      slave_hold = 0;
      read_ack = 1;
      @(negedge clk_i);
      read_ack = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
`ifdef REQ_WB_BRIDGE_TIMEOUT_EN
      test_timeout();
`endif
      test_overflow();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
